// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and digit types shared by the 7-segment scan driver
package seg7_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [6:0]         glyph_t;

  // Glyph bit order is {g,f,e,d,c,b,a}; 1 = segment lit
  localparam glyph_t SEG_BLANK = 7'b0000000;
  localparam glyph_t GLYPH_0   = 7'b0111111;
  localparam glyph_t GLYPH_1   = 7'b0000110;
  localparam glyph_t GLYPH_2   = 7'b1011011;
  localparam glyph_t GLYPH_3   = 7'b1001111;
  localparam glyph_t GLYPH_4   = 7'b1100110;
  localparam glyph_t GLYPH_5   = 7'b1101101;
  localparam glyph_t GLYPH_6   = 7'b1111101;
  localparam glyph_t GLYPH_7   = 7'b0000111;
  localparam glyph_t GLYPH_8   = 7'b1111111;
  localparam glyph_t GLYPH_9   = 7'b1101111;
  localparam glyph_t GLYPH_A   = 7'b1110111;
  localparam glyph_t GLYPH_B   = 7'b1111100;
  localparam glyph_t GLYPH_C   = 7'b0111001;
  localparam glyph_t GLYPH_D   = 7'b1011110;
  localparam glyph_t GLYPH_E   = 7'b1111001;
  localparam glyph_t GLYPH_F   = 7'b1110001;

  function automatic int packed_width(input int num_digits);
    return num_digits * DIGIT_W;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational 4-bit code to 7-segment glyph decoder
module seg7_glyph_decode
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  digit_t code_i,
  output glyph_t glyph_o
);

  localparam bit HEX = (HEX_MODE != 0);

  always_comb begin
    glyph_o = SEG_BLANK;
    case (code_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = HEX ? GLYPH_A : SEG_BLANK;
      4'hB: glyph_o = HEX ? GLYPH_B : SEG_BLANK;
      4'hC: glyph_o = HEX ? GLYPH_C : SEG_BLANK;
      4'hD: glyph_o = HEX ? GLYPH_D : SEG_BLANK;
      4'hE: glyph_o = HEX ? GLYPH_E : SEG_BLANK;
      4'hF: glyph_o = HEX ? GLYPH_F : SEG_BLANK;
      default: glyph_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment driver with blanking, dp and anti-ghost window
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int HEX_MODE       = 0,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic [packed_width(NUM_DIGITS)-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]               dp_in,
  input  logic                                blank_lz,
  output logic [6:0]                          seg,
  output logic                                dp,
  output logic [NUM_DIGITS-1:0]               an,
  output logic                                slot_start
);

  localparam int DW    = packed_width(NUM_DIGITS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam bit                    SEG_INV = (ACTIVE_LOW_SEG != 0);
  localparam bit                    AN_INV  = (ACTIVE_LOW_AN != 0);
  localparam glyph_t                SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic                  blz_q, blz_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  glyph_t                seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  slot_q, slot_d;

  logic   slot_end;
  logic   in_blank;
  digit_t cur_code;
  logic   cur_dp;
  logic   lz_blank;
  logic   all_zero;
  glyph_t cur_glyph;
  glyph_t lit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      dp_sh_q  <= '0;
      blz_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      an_q     <= AN_OFF;
      slot_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      dp_sh_q  <= dp_sh_d;
      blz_q    <= blz_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    digits_d = load ? digits_in : digits_q;
    dp_sh_d  = load ? dp_in     : dp_sh_q;
    blz_d    = load ? blank_lz  : blz_q;
  end

  always_comb begin
    slot_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    slot_d = slot_end;
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (int'(cnt_q) < BLANK_CYCLES);
    end
  endgenerate

  // Walk from the most significant digit down so all_zero tracks "every digit at or above i is 0"
  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    lz_blank = 1'b0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (digits_q[i*DIGIT_W +: DIGIT_W] == '0);
      if (int'(idx_q) == i) begin
        cur_code = digits_q[i*DIGIT_W +: DIGIT_W];
        cur_dp   = dp_sh_q[i];
        lz_blank = blz_q && (i != 0) && all_zero;
      end
    end
  end

  seg7_glyph_decode #(
    .HEX_MODE(HEX_MODE)
  ) u_decode (
    .code_i (cur_code),
    .glyph_o(cur_glyph)
  );

  always_comb begin
    lit   = SEG_BLANK;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (!in_blank) begin
      lit   = lz_blank ? SEG_BLANK : cur_glyph;
      seg_d = SEG_INV ? ~lit : lit;
      dp_d  = SEG_INV ? ~cur_dp : cur_dp;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (int'(idx_q) == i) ^ AN_INV;
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign slot_start = slot_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0] seg_h0, seg_h1;
  logic       dp_h0, dp_h1;
  logic [3:0] an_h0, an_h1;
  logic       ss_h0, ss_h1;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [6:0]  glyph_tab [16];

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dpv;
    logic        blz;
    int          digit;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic        dp_exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BC),
    .HEX_MODE(0), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
  ) dut_h0 (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_h0), .dp(dp_h0), .an(an_h0), .slot_start(ss_h0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BC),
    .HEX_MODE(1), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
  ) dut_h1 (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_h1), .dp(dp_h1), .an(an_h1), .slot_start(ss_h1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act[6:0], exp[6:0]);
    end
  endtask

  function automatic logic [6:0] ref_lit(input logic [3:0] code, input bit hex);
    if (code > 4'd9 && !hex) return 7'b0000000;
    return glyph_tab[code];
  endfunction

  task automatic model_reset();
    n        = 0;
    m_digits = '0;
    m_dp     = '0;
    m_blz    = 1'b0;
  endtask

  // One clock: predict outputs after this edge from the model state before it, then compare at negedge
  task automatic tick();
    int k, c, d;
    logic [3:0] e_an;
    logic [6:0] e_seg0, e_seg1;
    logic       e_dp, e_ss, blanked;
    @(posedge clk);
    n++;
    k    = n - 1;
    c    = k % CD;
    d    = (k / CD) % N;
    e_ss = (c == CD - 1);
    if (c < BC) begin
      e_an   = 4'hF;
      e_seg0 = 7'h7F;
      e_seg1 = 7'h7F;
      e_dp   = 1'b1;
    end else begin
      e_an    = ~(4'b0001 << d);
      blanked = m_blz && (d > 0) && ((m_digits >> (4 * d)) == 16'h0);
      e_seg0  = blanked ? 7'h7F : ~ref_lit(m_digits[4*d +: 4], 1'b0);
      e_seg1  = blanked ? 7'h7F : ~ref_lit(m_digits[4*d +: 4], 1'b1);
      e_dp    = ~m_dp[d];
    end
    if (load) begin
      m_digits = digits_in;
      m_dp     = dp_in;
      m_blz    = blank_lz;
    end
    @(negedge clk);
    check("an_h0", 32'(an_h0), 32'(e_an));
    check("an_h1", 32'(an_h1), 32'(e_an));
    check("seg_h0", 32'(seg_h0), 32'(e_seg0));
    check("seg_h1", 32'(seg_h1), 32'(e_seg1));
    check("dp_h0", 32'(dp_h0), 32'(e_dp));
    check("dp_h1", 32'(dp_h1), 32'(e_dp));
    check("slot_start_h0", 32'(ss_h0), 32'(e_ss));
    check("slot_start_h1", 32'(ss_h1), 32'(e_ss));
  endtask

  task automatic do_load(input logic [15:0] dv, input logic [3:0] dpv, input logic blz);
    digits_in = dv;
    dp_in     = dpv;
    blank_lz  = blz;
    load      = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5 * CD * N; i++) begin
      if (an_h0 === pat) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_an timeout: an=%b never reached %b", an_h0, pat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gap;
    logic [3:0] first_an;

    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vecs.push_back('{16'h1234, 4'h0, 1'b0, 0, 7'b0011001, 7'b0011001, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 1'b0, 1, 7'b0110000, 7'b0110000, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 1'b0, 2, 7'b0100100, 7'b0100100, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 1'b0, 3, 7'b1111001, 7'b1111001, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 1'b1, 3, 7'b1111111, 7'b1111111, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 1'b1, 2, 7'b1111111, 7'b1111111, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 1'b1, 1, 7'b0010010, 7'b0010010, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 1'b1, 0, 7'b1000000, 7'b1000000, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 1'b0, 3, 7'b1000000, 7'b1000000, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 1'b0, 2, 7'b1000000, 7'b1000000, 1'b1});
    vecs.push_back('{16'hA0F0, 4'b0100, 1'b0, 3, 7'b1111111, 7'b0001000, 1'b1});
    vecs.push_back('{16'hA0F0, 4'b0100, 1'b0, 2, 7'b1000000, 7'b1000000, 1'b0});
    vecs.push_back('{16'hA0F0, 4'b0100, 1'b0, 1, 7'b1111111, 7'b0001110, 1'b1});
    vecs.push_back('{16'hA0F0, 4'b0100, 1'b1, 2, 7'b1000000, 7'b1000000, 1'b0});
    vecs.push_back('{16'h0000, 4'b0010, 1'b1, 1, 7'b1111111, 7'b1111111, 1'b0});
    vecs.push_back('{16'h0000, 4'b0010, 1'b1, 0, 7'b1000000, 7'b1000000, 1'b1});
    vecs.push_back('{16'h8888, 4'h0, 1'b0, 2, 7'b0000000, 7'b0000000, 1'b1});

    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blank_lz  = 1'b0;
    #22;
    check("reset_an", 32'(an_h0), 32'hF);
    check("reset_seg", 32'(seg_h0), 32'h7F);
    check("reset_dp", 32'(dp_h0), 32'h1);
    check("reset_slot_start", 32'(ss_h0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * CD; i++) tick();

    foreach (vecs[v]) begin
      do_load(vecs[v].digits, vecs[v].dpv, vecs[v].blz);
      wait_an(~(4'b0001 << vecs[v].digit), ok);
      if (ok) begin
        check($sformatf("vec%0d_seg_h0", v), 32'(seg_h0), 32'(vecs[v].seg0));
        check($sformatf("vec%0d_seg_h1", v), 32'(seg_h1), 32'(vecs[v].seg1));
        check($sformatf("vec%0d_dp", v), 32'(dp_h0), 32'(vecs[v].dp_exp));
      end
    end

    do_load(16'h1234, 4'h0, 1'b0);
    wait_an(4'b1110, ok);
    tick();
    digits_in = 16'h9999;
    load      = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("midslot_seg", 32'(seg_h0), 32'(7'b0010000));
    check("midslot_an", 32'(an_h0), 32'(4'b1110));
    gap = 0;
    while (!ss_h0 && gap < 4 * CD) begin
      tick();
      gap++;
    end
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!ss_h0 && gap < 4 * CD);
    check("slot_period", 32'(gap), 32'(CD));

    wait_an(4'b1011, ok);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an_h0), 32'hF);
    check("async_rst_seg", 32'(seg_h0), 32'h7F);
    check("async_rst_slot_start", 32'(ss_h0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    first_an = 4'hF;
    for (int i = 0; i < 2 * CD && first_an == 4'hF; i++) begin
      tick();
      first_an = an_h0;
    end
    check("first_digit_after_reset", 32'(first_an), 32'(4'b1110));

    for (int i = 0; i < 600; i++) begin
      load      = ($urandom_range(0, 7) == 0);
      digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in     = 4'($urandom);
      blank_lz  = 1'($urandom);
      tick();
    end
    load = 1'b0;
    for (int i = 0; i < CD * N; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
